// File: rtl/phrase_step_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phrase_step_iter_pkg
// Description : Shared types and constants for the phrase step iterator.
//               Sequencer state encoding, lane geometry and a lane-slice
//               helper for 64-bit phrases built from four 16-bit lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package phrase_step_iter_pkg;

    localparam int c_LANE_W   = 16;
    localparam int c_LANE_CNT = 4;
    localparam int c_PHRASE_W = c_LANE_W * c_LANE_CNT;
    localparam int c_MODE_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Lane n of a phrase occupies bits [16n+15:16n].
    function automatic logic [c_LANE_W-1:0] lane_of(
        input logic [c_PHRASE_W-1:0] phrase,
        input int                    n
    );
        return phrase[n*c_LANE_W +: c_LANE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/phrase_step_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : phrase_step_iter_if
// Description : Phrase output handshake between the iterator (master) and
//               the downstream pixel writer (slave).
//               phr_valid : phrase offered
//               phr_ready : downstream accepts phrase
//               phr_data  : 64-bit iterated phrase
// Revision    : 1.0 - initial release
// ============================================================================
interface phrase_step_iter_if;
    import phrase_step_iter_pkg::*;

    logic                  phr_valid;
    logic                  phr_ready;
    logic [c_PHRASE_W-1:0] phr_data;

    modport master (output phr_valid, output phr_data, input  phr_ready);
    modport slave  (input  phr_valid, input  phr_data, output phr_ready);

endinterface
`default_nettype wire

// File: rtl/phrase_step_lane.sv
`default_nettype none
// ============================================================================
// Module      : phrase_step_lane
// Description : One 16-bit lane: accumulator plus step register.
//               load_i : capture init_i/step_i (start of run)
//               upd_i  : capture addq_i into the accumulator (accepted phrase)
//               acc_o  : accumulator, step_o : step value
// Revision    : 1.0 - initial release
// ============================================================================
module phrase_step_lane
    import phrase_step_iter_pkg::*;
(
    input  wire logic                sys_clk,
    input  wire logic                reset_n,
    input  wire logic                load_i,
    input  wire logic                upd_i,
    input  wire logic [c_LANE_W-1:0] init_i,
    input  wire logic [c_LANE_W-1:0] step_i,
    input  wire logic [c_LANE_W-1:0] addq_i,
    output      logic [c_LANE_W-1:0] acc_o,
    output      logic [c_LANE_W-1:0] step_o
);

    logic [c_LANE_W-1:0] acc_q, acc_d;
    logic [c_LANE_W-1:0] step_q, step_d;

    always_comb begin
        acc_d  = acc_q;
        step_d = step_q;
        if (load_i) begin
            acc_d  = init_i;
            step_d = step_i;
        end else if (upd_i) begin
            acc_d  = addq_i;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end

    assign acc_o  = acc_q;
    assign step_o = step_q;

endmodule
`default_nettype wire

// File: rtl/phrase_step_iter.sv
`default_nettype none
// ============================================================================
// Module      : phrase_step_iter
// Description : Operand sequencer for the 4x16-bit saturating add array.
//               Feeds accumulator/step lanes to the array, captures addq as
//               the next accumulator on every accepted phrase, and emits
//               count_in phrases over the phr handshake.
//   sys_clk, reset_n         : clock, async active-low reset
//   start, init_phrase,
//   step_phrase, mode_in,
//   count_in                 : run request and parameters (latched at start)
//   adda_n, addb_n, daddmode : operands / mode to the add array
//   addq_n                   : add array results
//   phr                      : phrase output handshake (master)
//   busy, done               : run status, one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module phrase_step_iter
    import phrase_step_iter_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int LANES = 4
) (
    input  wire logic                sys_clk,
    input  wire logic                reset_n,
    input  wire logic                start,
    input  wire logic [63:0]         init_phrase,
    input  wire logic [63:0]         step_phrase,
    input  wire logic [2:0]          mode_in,
    input  wire logic [CNT_W-1:0]    count_in,
    output      logic [15:0]         adda_0,
    output      logic [15:0]         adda_1,
    output      logic [15:0]         adda_2,
    output      logic [15:0]         adda_3,
    output      logic [15:0]         addb_0,
    output      logic [15:0]         addb_1,
    output      logic [15:0]         addb_2,
    output      logic [15:0]         addb_3,
    output      logic [2:0]          daddmode,
    input  wire logic [15:0]         addq_0,
    input  wire logic [15:0]         addq_1,
    input  wire logic [15:0]         addq_2,
    input  wire logic [15:0]         addq_3,
    phrase_step_iter_if.master       phr,
    output      logic                busy,
    output      logic                done
);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [c_MODE_W-1:0]   mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  w_load;
    logic                  w_upd;

    logic [c_LANE_W-1:0]   w_addq [c_LANE_CNT];
    logic [c_LANE_W-1:0]   w_acc  [c_LANE_CNT];
    logic [c_LANE_W-1:0]   w_step [c_LANE_CNT];

    assign w_addq[0] = addq_0;
    assign w_addq[1] = addq_1;
    assign w_addq[2] = addq_2;
    assign w_addq[3] = addq_3;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lanes
            phrase_step_lane u_lane (
                .sys_clk (sys_clk),
                .reset_n (reset_n),
                .load_i  (w_load),
                .upd_i   (w_upd),
                .init_i  (lane_of(init_phrase, i)),
                .step_i  (lane_of(step_phrase, i)),
                .addq_i  (w_addq[i]),
                .acc_o   (w_acc[i]),
                .step_o  (w_step[i])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        w_load  = 1'b0;
        w_upd   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count_in != '0) begin
                        w_load  = 1'b1;
                        mode_d  = mode_in;
                        cnt_d   = count_in;
                        state_d = ST_LOAD;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            // Operands change here; the array output settles before RUN.
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (phr.phr_ready) begin
                    w_upd = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // The array's carry latch clocks every cycle, so the mode (and with it
    // cinsel) is only presented on cycles where the result is captured.
    assign daddmode = (state_q == ST_RUN && phr.phr_ready) ? mode_q : '0;

    assign adda_0 = w_acc[0];
    assign adda_1 = w_acc[1];
    assign adda_2 = w_acc[2];
    assign adda_3 = w_acc[3];
    assign addb_0 = w_step[0];
    assign addb_1 = w_step[1];
    assign addb_2 = w_step[2];
    assign addb_3 = w_step[3];

    assign phr.phr_valid = (state_q == ST_RUN);
    assign phr.phr_data  = {w_acc[3], w_acc[2], w_acc[1], w_acc[0]};
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_phrase_step_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_phrase_step_iter
// Description : Scoreboard bench for phrase_step_iter with a behavioural
//               add array (mode 001 saturates unsigned, others wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phrase_step_iter;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [63:0] init_phrase = '0;
    logic [63:0] step_phrase = '0;
    logic [2:0]  mode_in  = '0;
    logic [15:0] count_in = '0;
    logic [15:0] adda_0, adda_1, adda_2, adda_3;
    logic [15:0] addb_0, addb_1, addb_2, addb_3;
    logic [15:0] addq_0, addq_1, addq_2, addq_3;
    logic [2:0]  daddmode;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    int          done_exp = 0;

    phrase_step_iter_if u_if ();

    phrase_step_iter #(.CNT_W(16), .LANES(4)) u_dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .start       (start),
        .init_phrase (init_phrase),
        .step_phrase (step_phrase),
        .mode_in     (mode_in),
        .count_in    (count_in),
        .adda_0      (adda_0),
        .adda_1      (adda_1),
        .adda_2      (adda_2),
        .adda_3      (adda_3),
        .addb_0      (addb_0),
        .addb_1      (addb_1),
        .addb_2      (addb_2),
        .addb_3      (addb_3),
        .daddmode    (daddmode),
        .addq_0      (addq_0),
        .addq_1      (addq_1),
        .addq_2      (addq_2),
        .addq_3      (addq_3),
        .phr         (u_if),
        .busy        (busy),
        .done        (done)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] arr_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] m);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (m == 3'b001 && s[16]) return 16'hFFFF;
        return s[15:0];
    endfunction

    assign addq_0 = arr_add(adda_0, addb_0, daddmode);
    assign addq_1 = arr_add(adda_1, addb_1, daddmode);
    assign addq_2 = arr_add(adda_2, addb_2, daddmode);
    assign addq_3 = arr_add(adda_3, addb_3, daddmode);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Pulses start for one cycle; returns in the cycle after the start edge.
    task automatic launch(input logic [63:0] ini, input logic [63:0] stp,
                          input logic [2:0] m, input logic [15:0] cnt);
        init_phrase = ini;
        step_phrase = stp;
        mode_in     = m;
        count_in    = cnt;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Monitor: consumes expected phrases on every handshake, and expected
    // done pulses whenever done is seen.
    always @(negedge sys_clk) begin
        if (reset_n) begin
            if (u_if.phr_valid && u_if.phr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("phr_unexpected", u_if.phr_data, 64'hx);
                end else begin
                    chk("phr_data", u_if.phr_data, exp_q.pop_front());
                end
            end
            if (done) begin
                chk("done_expected", 64'(done_exp > 0), 64'd1);
                if (done_exp > 0) done_exp--;
            end
        end
    end

    initial begin
        u_if.phr_ready = 1'b1;

        // ---- reset state ----
        tick(); tick();
        chk("rst_valid", u_if.phr_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_adda",  {adda_3, adda_2, adda_1, adda_0}, 0);
        chk("rst_addb",  {addb_3, addb_2, addb_1, addb_0}, 0);
        chk("rst_mode",  daddmode, 0);
        reset_n = 1'b1;
        tick();

        // ---- basic run, distinct lanes, ready high ----
        exp_q.push_back(64'h0310_0210_0110_0010);
        exp_q.push_back(64'h0314_0213_0112_0011);
        exp_q.push_back(64'h0318_0216_0114_0012);
        done_exp++;
        launch(64'h0310_0210_0110_0010, 64'h0004_0003_0002_0001, 3'b000, 16'd3);
        chk("load_valid", u_if.phr_valid, 0);
        chk("load_busy",  busy, 1);
        tick();
        chk("run_valid",  u_if.phr_valid, 1);
        tick(); tick(); tick();
        chk("t1_done",    done, 1);
        chk("t1_valid",   u_if.phr_valid, 0);
        tick();
        chk("t1_done_off", done, 0);
        chk("t1_idle",    busy, 0);

        // ---- backpressure, mode 001 ----
        u_if.phr_ready = 1'b0;
        exp_q.push_back({4{16'h0010}});
        exp_q.push_back({4{16'h0011}});
        exp_q.push_back({4{16'h0012}});
        done_exp++;
        launch({4{16'h0010}}, {4{16'h0001}}, 3'b001, 16'd3);
        chk("t2_load_mode", daddmode, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_valid", u_if.phr_valid, 1);
            chk("t2_stall_data",  u_if.phr_data, {4{16'h0010}});
            chk("t2_stall_mode",  daddmode, 0);
            tick();
        end
        u_if.phr_ready = 1'b1;
        #1;
        chk("t2_run_mode", daddmode, 3'b001);
        tick(); tick(); tick();
        chk("t2_done", done, 1);
        tick();
        chk("t2_count", exp_q.size(), 0);

        // ---- count zero ----
        done_exp++;
        launch({4{16'hAAAA}}, {4{16'h0001}}, 3'b000, 16'd0);
        chk("t3_done",  done, 1);
        chk("t3_busy",  busy, 0);
        chk("t3_valid", u_if.phr_valid, 0);
        tick();
        chk("t3_done_off", done, 0);
        chk("t3_busy2",    busy, 0);

        // ---- saturating mode ----
        exp_q.push_back(64'hFFF0_FFF0_FFF0_0010);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_0030);
        done_exp++;
        launch(64'hFFF0_FFF0_FFF0_0010, {4{16'h0020}}, 3'b001, 16'd2);
        tick();
        chk("t4_mode", daddmode, 3'b001);
        tick(); tick();
        chk("t4_done", done, 1);
        tick();

        // ---- reset mid-run ----
        exp_q.push_back(64'h4000_3000_2000_1000);
        launch(64'h4000_3000_2000_1000, {4{16'h0100}}, 3'b000, 16'd5);
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("t5_valid", u_if.phr_valid, 0);
        chk("t5_busy",  busy, 0);
        chk("t5_adda",  {adda_3, adda_2, adda_1, adda_0}, 0);
        chk("t5_done",  done, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("t5_no_done", done, 0);
        chk("t5_idle",    busy, 0);
        exp_q.push_back({4{16'h2000}});
        exp_q.push_back({4{16'h2001}});
        done_exp++;
        launch({4{16'h2000}}, {4{16'h0001}}, 3'b000, 16'd2);
        tick(); tick(); tick();
        chk("t5_rerun_done", done, 1);
        tick();

        // ---- start during RUN ignored ----
        exp_q.push_back({4{16'h0100}});
        exp_q.push_back({4{16'h0110}});
        exp_q.push_back({4{16'h0120}});
        done_exp++;
        launch({4{16'h0100}}, {4{16'h0010}}, 3'b000, 16'd3);
        tick();
        init_phrase = {4{16'h7777}};
        step_phrase = {4{16'h0555}};
        mode_in     = 3'b001;
        count_in    = 16'd9;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_busy", busy, 1);
        tick(); tick();
        chk("t6_done", done, 1);
        tick();
        chk("t6_idle", busy, 0);
        tick(); tick();

        chk("final_phr_queue",  exp_q.size(), 0);
        chk("final_done_queue", done_exp, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
